// File: rtl/axi_lite_sram_sub.sv
// axi_lite_sram_sub
//
// AXI4-Lite subordinate that terminates the write (AW/W/B) and read (AR/R)
// channels onto a word-addressed on-chip SRAM. It returns OKAY for in-range
// accesses and SLVERR for out-of-range ones. Byte-lane write strobes are
// honoured, and each direction keeps one transaction outstanding.
//
// Ports
//   clk, resetn              clock; asynchronous active-low reset
//   axi_aw*                  write address channel (addr, valid, ready)
//   axi_w*                   write data channel (data, strb, valid, ready)
//   axi_b*                   write response channel (resp, valid, ready)
//   axi_ar*                  read address channel (addr, valid, ready)
//   axi_r*                   read data channel (data, resp, valid, ready)
//
// Parameters
//   ADDR_WIDTH               AXI address width
//   DATA_WIDTH               AXI data width, fixed at 32 (4 byte lanes)
//   MEM_WORDS                SRAM depth in words, power of two
//   BASE_ADDR                byte address of word 0, aligned to MEM_WORDS*4

module axi_lite_sram_sub #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  // Write address
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  // Write data
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  // Write response
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  // Read address
  input  logic [ADDR_WIDTH-1:0]     axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  // Read data
  output logic [DATA_WIDTH-1:0]     axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  // Lowest address bit above the word index; bits from here up must match the base.
  localparam int unsigned HiLsb = IdxW + 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Because BASE_ADDR is aligned to the SRAM size, the range check reduces to
  // comparing the upper address bits, and the offset's index bits equal the
  // address's index bits.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:HiLsb] == BASE_ADDR[ADDR_WIDTH-1:HiLsb];
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[HiLsb-1:2];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  init_q;

  logic                  aw_got_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  w_got_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;

  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Handshakes and commit decode
  // ---------------------------------------------------------------------------
  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]      wr_strb;
  logic                  wr_in_range;
  logic [IdxW-1:0]       wr_idx;
  logic                  rd_in_range;
  logic [IdxW-1:0]       rd_idx;

  // Readies depend only on registered state, never on the same-channel valid.
  always_comb begin
    axi_awready = init_q & ~aw_got_q & ~bvalid_q;
    axi_wready  = init_q & ~w_got_q & ~bvalid_q;
    axi_arready = init_q & ~rvalid_q;
  end

  always_comb begin
    aw_hs  = axi_awvalid & axi_awready;
    w_hs   = axi_wvalid & axi_wready;
    ar_hs  = axi_arvalid & axi_arready;
    // Each half is either already buffered or arriving on this edge.
    commit = (aw_got_q | aw_hs) & (w_got_q | w_hs);

    wr_addr     = aw_got_q ? awaddr_q : axi_awaddr;
    wr_data     = w_got_q ? wdata_q : axi_wdata;
    wr_strb     = w_got_q ? wstrb_q : axi_wstrb;
    wr_in_range = addr_in_range(wr_addr);
    wr_idx      = addr_idx(wr_addr);

    rd_in_range = addr_in_range(axi_araddr);
    rd_idx      = addr_idx(axi_araddr);
  end

  // The byte offset within a word is ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0], awaddr_q[1:0]};

  // ---------------------------------------------------------------------------
  // Init flag: keeps all readies low until the first edge out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path: AW/W holding registers and B response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_got_q <= 1'b0;
      awaddr_q <= '0;
      w_got_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_got_q <= 1'b1;
        awaddr_q <= axi_awaddr;
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= axi_wdata;
        wstrb_q <= axi_wstrb;
      end
    end
  end

  // A commit only happens while bvalid is low, since both readies are gated by it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_in_range ? RespOkay : RespSlverr;
    end else if (bvalid_q && axi_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // SRAM array: never reset, so contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (commit && wr_in_range) begin
      for (int i = 0; i < int'(StrbW); i++) begin
        if (wr_strb[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. A read on the same edge as a write commit to the same word
  // samples the array before the non-blocking update, returning old data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (rd_in_range) begin
        rdata_q <= mem_q[rd_idx];
        rresp_q <= RespOkay;
      end else begin
        rdata_q <= '0;
        rresp_q <= RespSlverr;
      end
    end else if (rvalid_q && axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    axi_bvalid = bvalid_q;
    axi_bresp  = bresp_q;
    axi_rvalid = rvalid_q;
    axi_rresp  = rresp_q;
    axi_rdata  = rdata_q;
  end

endmodule
